// File: rtl/pulse_window_counter.sv
// pulse_window_counter
// Samples a single pulse/level signal once per clock and counts its rising
// edges over fixed windows of WINDOW cycles. At every window boundary the
// count is published with a one-cycle valid strobe and an activity flag.
//
// Optional build macro: PWC_STICKY_ERR_EN
//   undefined (default): err reports, on each valid cycle, whether the
//                        window that just closed hit the accumulator ceiling.
//   defined            : err latches high the cycle after any counted edge
//                        and stays high until reset or clear.
module pulse_window_counter #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             valid,
    output logic             active,
    output logic             err
);

    // Window position counter only ever needs to reach WINDOW-1.
    localparam int WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WCNT_W-1:0] WCNT_PRE = WCNT_W'(WINDOW - 2);
    localparam logic [WIDTH-1:0]  ACC_MAX  = '1;

    // RUN covers every window cycle except the last; FLUSH is the last one.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state_reg;
    logic [WCNT_W-1:0] wcnt_reg;
    logic [WIDTH-1:0]  acc_reg;
    logic              a_prev_reg;
    logic [WIDTH-1:0]  count_reg;
    logic              valid_reg;
    logic              active_reg;
    logic              err_reg;

    logic              edge_det;
    logic [WIDTH-1:0]  acc_next;

    assign edge_det = a & ~a_prev_reg;

    // Saturating accumulate: once at the ceiling, further edges are dropped.
    always_comb begin
        acc_next = acc_reg;
        if (acc_reg != ACC_MAX) begin
            acc_next = acc_reg + WIDTH'(edge_det);
        end
    end

    // Previous-sample register; tracks the input on every non-reset cycle,
    // including clear cycles, so a level held across a clear is not recounted.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_prev_reg <= 1'b0;
        end else begin
            a_prev_reg <= a;
        end
    end

    // Window FSM: accumulates edges in RUN and publishes the result in FLUSH.
    // An edge seen on the FLUSH cycle is folded into the closing window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= RUN;
            wcnt_reg   <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            valid_reg  <= 1'b0;
            active_reg <= 1'b0;
        end else if (clear) begin
            // Restart the window; published results are left untouched and
            // a flush falling on this cycle is cancelled.
            state_reg <= RUN;
            wcnt_reg  <= '0;
            acc_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    acc_reg   <= acc_next;
                    wcnt_reg  <= wcnt_reg + WCNT_W'(1);
                    valid_reg <= 1'b0;
                    state_reg <= (wcnt_reg == WCNT_PRE) ? FLUSH : RUN;
                end
                FLUSH: begin
                    count_reg  <= acc_next;
                    active_reg <= (acc_next != '0);
                    valid_reg  <= 1'b1;
                    acc_reg    <= '0;
                    wcnt_reg   <= '0;
                    state_reg  <= RUN;
                end
                default: begin
                    state_reg <= RUN;
                    wcnt_reg  <= '0;
                    acc_reg   <= '0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef PWC_STICKY_ERR_EN
    // Sticky alarm: any edge that is actually counted raises err until
    // reset or clear; edges on a clear cycle are discarded and do not count.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            err_reg <= 1'b0;
        end else if (edge_det) begin
            err_reg <= 1'b1;
        end
    end
`else
    // Saturation flag: refreshed only with valid, high when the closing
    // window's count reached the accumulator ceiling.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (!clear && state_reg == FLUSH) begin
            err_reg <= (acc_next == ACC_MAX);
        end
    end
`endif

    assign count  = count_reg;
    assign valid  = valid_reg;
    assign active = active_reg;
    assign err    = err_reg;

endmodule

// File: tb/tb_pulse_window_counter.sv
// Randomized and directed bench for pulse_window_counter. A cycle-level
// reference model tracks edges as plain integers (cycles since window start,
// unbounded edge total clipped at publish time) and every output is compared
// after each clock.
module tb_pulse_window_counter;

    localparam int WIDTH  = 3;
    localparam int WINDOW = 16;
    localparam int MAXV   = (1 << WIDTH) - 1;

    logic             clk;
    logic             reset;
    logic             a;
    logic             clear;
    logic [WIDTH-1:0] count;
    logic             valid;
    logic             active;
    logic             err;

    int checks;
    int errors;

    // reference model state
    int m_prev;
    int m_cyc;
    int m_edges;
    int m_count;
    int m_valid;
    int m_active;
    int m_err;

    pulse_window_counter #(
        .WIDTH (WIDTH),
        .WINDOW(WINDOW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .clear (clear),
        .count (count),
        .valid (valid),
        .active(active),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model of one clock edge with the given inputs.
    task automatic model_tick(input logic r, input logic c, input logic av);
        int e;
        if (r) begin
            m_prev = 0; m_cyc = 0; m_edges = 0;
            m_count = 0; m_valid = 0; m_active = 0; m_err = 0;
        end else begin
            e = (av && m_prev == 0) ? 1 : 0;
            m_prev = av ? 1 : 0;
            if (c) begin
                m_edges = 0;
                m_cyc   = 0;
                m_valid = 0;
`ifdef PWC_STICKY_ERR_EN
                m_err = 0;
`endif
            end else begin
                m_edges += e;
`ifdef PWC_STICKY_ERR_EN
                if (e != 0) m_err = 1;
`endif
                if (m_cyc == WINDOW - 1) begin
                    m_count  = (m_edges > MAXV) ? MAXV : m_edges;
                    m_active = (m_count != 0) ? 1 : 0;
`ifndef PWC_STICKY_ERR_EN
                    m_err = (m_count == MAXV) ? 1 : 0;
`endif
                    m_valid = 1;
                    m_edges = 0;
                    m_cyc   = 0;
                end else begin
                    m_cyc++;
                    m_valid = 0;
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, model on the rising edge,
    // compare 1 time unit later.
    task automatic step(input logic r, input logic c, input logic av);
        @(negedge clk);
        reset = r;
        clear = c;
        a     = av;
        @(posedge clk);
        model_tick(r, c, av);
        #1;
        check_eq("count",  int'(count),  m_count);
        check_eq("valid",  int'(valid),  m_valid);
        check_eq("active", int'(active), m_active);
        check_eq("err",    int'(err),    m_err);
        if (valid)
            $display("window closed t=%0t: count=%0d active=%0d err=%0d", $time, count, active, err);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int nvalid;
        int dens;
        logic r, c, av;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        clear = 1'b0;
        a     = 1'b0;
        m_prev = 0; m_cyc = 0; m_edges = 0;
        m_count = 0; m_valid = 0; m_active = 0; m_err = 0;

        // reset state
        do_reset();
        check_eq("reset_count", int'(count), 0);
        check_eq("reset_valid", int'(valid), 0);

        // 1: constant 0 for 50 cycles -> strobes at 16, 32, 48
        nvalid = 0;
        for (int s = 1; s <= 50; s++) begin
            step(1'b0, 1'b0, 1'b0);
            if (valid) nvalid++;
            if (s % WINDOW == 0) check_eq("t1_valid_at_boundary", int'(valid), 1);
        end
        check_eq("t1_valid_total", nvalid, 3);

        // 2: pulses at cycles 2, 5, 9
        do_reset();
        for (int s = 1; s <= 32; s++) begin
            step(1'b0, 1'b0, (s == 2 || s == 5 || s == 9));
            if (s == 16) begin
                check_eq("t2_count_w0", int'(count), 3);
                check_eq("t2_active_w0", int'(active), 1);
            end
            if (s == 32) begin
                check_eq("t2_count_w1", int'(count), 0);
                check_eq("t2_active_w1", int'(active), 0);
            end
        end

        // 3: level held high from 4 to 40 counts once
        do_reset();
        for (int s = 1; s <= 48; s++) begin
            step(1'b0, 1'b0, (s >= 4 && s <= 40));
            if (s == 16) check_eq("t3_count_w0", int'(count), 1);
            if (s == 32) check_eq("t3_count_w1", int'(count), 0);
            if (s == 48) check_eq("t3_count_w2", int'(count), 0);
        end

        // 4: pulse on the FLUSH cycle belongs to the closing window
        do_reset();
        for (int s = 1; s <= 32; s++) begin
            step(1'b0, 1'b0, (s == 16));
            if (s == 16) check_eq("t4_count_w0", int'(count), 1);
            if (s == 32) check_eq("t4_count_w1", int'(count), 0);
        end

        // 5 + 6: saturation, clear on the flush cycle, reset mid-window
        do_reset();
        for (int s = 1; s <= 60; s++) begin
            r  = (s == 56);
            c  = (s == 32);
            av = (s <= 16) ? (s % 2 == 1) : (s == 19 || s == 22 || s == 50);
            step(r, c, av);
            if (s == 16) begin
                check_eq("t5_count_sat", int'(count), MAXV);
                check_eq("t5_err_sat", int'(err), 1);
            end
            if (s == 32) begin
                check_eq("t6_clear_no_valid", int'(valid), 0);
                check_eq("t6_clear_count_hold", int'(count), MAXV);
            end
            if (s == 48) begin
                check_eq("t6_valid_after_clear", int'(valid), 1);
                check_eq("t6_count_after_clear", int'(count), 0);
            end
            if (s == 56) begin
                check_eq("t6_reset_count", int'(count), 0);
                check_eq("t6_reset_active", int'(active), 0);
                check_eq("t6_reset_err", int'(err), 0);
            end
        end

        // randomized traffic with varying pulse density
        dens = 30;
        for (int i = 0; i < 600; i++) begin
            if (i % 64 == 0) dens = $urandom_range(0, 100);
            r  = ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 63) == 0);
            av = ($urandom_range(0, 99) < dens);
            step(r, c, av);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
